pengo_input_cond: RTL and testbench



---
 rtl/pengo_input_cond_if.sv | 14 +
 rtl/pengo_input_cond.sv | 98 +++++++++
 tb/tb_pengo_input_cond.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pengo_input_cond_if.sv
// pengo_input_cond_if: joystick/coin inputs and core input bytes of the input conditioning stage
interface pengo_input_cond_if;
  logic       ena_6;
  logic       vblank;
  logic       cocktail;
  logic [5:0] p1;
  logic [5:0] p2;
  logic       coin;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       coin_busy;
  modport master (output ena_6, vblank, cocktail, p1, p2, coin, input in0, in1, coin_busy);
  modport slave (input ena_6, vblank, cocktail, p1, p2, coin, output in0, in1, coin_busy);
endinterface

// File: rtl/pengo_input_cond.sv
// pengo_input_cond: sync, debounce, coin pulse shaping and control mapping for the Pengo core inputs
module pengo_input_cond #(
  parameter int DEB_TICKS   = 12000,
  parameter int COIN_FRAMES = 4,
  parameter int COIN_QUEUE  = 3
) (
  input logic clk,
  input logic reset,
  pengo_input_cond_if.slave bus
);
  localparam int DW = DEB_TICKS > 1 ? $clog2(DEB_TICKS) : 1;
  localparam int FW = COIN_FRAMES > 1 ? $clog2(COIN_FRAMES) : 1;
  localparam int PW = $clog2(COIN_QUEUE + 1);
  typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_t;
  logic [12:0] raw, s1, s2, deb;
  logic coin_d, vblank_d, vrise, crise, inc, dec;
  state_t state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [PW-1:0] pending;
  logic [7:0] in0_q, in1_q;
  logic [3:0] dir0, dir1;
  logic fire0, fire1;
  assign raw = {bus.coin, bus.p2, bus.p1};
  // two-flop synchroniser on every raw bit
  always_ff @(posedge clk or posedge reset)
    if (reset) {s2, s1} <= '0;
    else {s2, s1} <= {s1, raw};
  for (genvar i = 0; i < 13; i++) begin : g_deb
    logic [DW-1:0] c;
    logic d;
    assign deb[i] = d;
    // accept a new level only after DEB_TICKS consecutive mismatching ticks
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        c <= '0;
        d <= 1'b0;
      end else if (bus.ena_6) begin
        if (s2[i] == d) c <= '0;
        else if (c == DW'(DEB_TICKS - 1)) begin
          c <= '0;
          d <= s2[i];
        end else c <= c + 1'b1;
      end
  end
  assign crise = deb[12] & ~coin_d;
  assign vrise = bus.vblank & ~vblank_d;
  assign inc = crise & (dec | (pending != PW'(COIN_QUEUE)));
  // coin FSM next state: pulse for COIN_FRAMES frames, then guard for the same count
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    dec = 1'b0;
    if (state == IDLE) begin
      if (pending != '0) begin
        state_n = PULSE;
        fcnt_n = '0;
        dec = 1'b1;
      end
    end else if (vrise) begin
      if (fcnt == FW'(COIN_FRAMES - 1)) begin
        state_n = state == PULSE ? GUARD : IDLE;
        fcnt_n = '0;
      end else fcnt_n = fcnt + 1'b1;
    end
  end
  // coin FSM state, frame counter, pending-coin queue and edge-detect history;
  // vblank_d starts high so a vblank already high at reset release is not a frame tick
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      fcnt <= '0;
      pending <= '0;
      coin_d <= 1'b0;
      vblank_d <= 1'b1;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      pending <= pending + PW'(inc) - PW'(dec);
      coin_d <= deb[12];
      vblank_d <= bus.vblank;
    end
  assign dir0 = bus.cocktail ? deb[3:0] : deb[3:0] | deb[9:6];
  assign fire0 = bus.cocktail ? deb[4] : deb[4] | deb[10];
  assign dir1 = bus.cocktail ? deb[9:6] : deb[3:0] | deb[9:6];
  assign fire1 = bus.cocktail ? deb[10] : deb[4] | deb[10];
  // registered active-low core input bytes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in0_q <= 8'hFF;
      in1_q <= 8'hFF;
    end else begin
      in0_q <= ~{fire0, 1'b0, state == PULSE, 1'b0, dir0};
      in1_q <= ~{fire1, deb[11], deb[5], 1'b0, dir1};
    end
  assign bus.in0 = in0_q;
  assign bus.in1 = in1_q;
  assign bus.coin_busy = (state != IDLE) || (pending != '0);
endmodule

// File: tb/tb_pengo_input_cond.sv
// tb_pengo_input_cond: scoreboard bench for debounce, coin shaping, queue saturation, mapping and reset
module tb_pengo_input_cond;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  string tag_q[$];
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  pengo_input_cond_if bus();
  pengo_input_cond #(.DEB_TICKS(4), .COIN_FRAMES(4), .COIN_QUEUE(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [7:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask
  task automatic pop(input logic [7:0] got);
    if (exp_q.size() == 0) chk("sb_underflow", got, ~got);
    else chk(tag_q.pop_front(), got, exp_q.pop_front());
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.ena_6) @(posedge clk);
    end
  endtask
  task automatic settle;
    clks(2);
    ticks(5);
    clks(2);
  endtask
  task automatic frame;
    @(negedge clk) bus.vblank = 1'b1;
    clks(2);
    @(negedge clk) bus.vblank = 1'b0;
    clks(2);
  endtask
  task automatic coin_press;
    @(negedge clk) bus.coin = 1'b1;
    settle();
    @(negedge clk) bus.coin = 1'b0;
    settle();
  endtask
  function automatic logic [7:0] busy();
    return {7'b0, bus.coin_busy};
  endfunction
  initial begin
    int n;
    n = 0;
    bus.ena_6 = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      bus.ena_6 = (n % 4 == 0);
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    bus.vblank = 1'b0;
    bus.cocktail = 1'b0;
    bus.p1 = '0;
    bus.p2 = '0;
    bus.coin = 1'b0;
    clks(3);
    #1;
    push("rst_in0", 8'hFF); pop(bus.in0);
    push("rst_in1", 8'hFF); pop(bus.in1);
    push("rst_busy", 8'h00); pop(busy());
    @(negedge clk) reset = 1'b0;
    clks(20);
    #1;
    push("idle_in0", 8'hFF); pop(bus.in0);
    push("idle_in1", 8'hFF); pop(bus.in1);
    @(negedge clk) bus.p1[0] = 1'b1;
    clks(2);
    ticks(3);
    @(negedge clk) bus.p1[0] = 1'b0;
    clks(20);
    #1;
    push("glitch", 8'hFF); pop(bus.in0);
    @(negedge clk) bus.p1[0] = 1'b1;
    clks(2);
    ticks(4);
    #1;
    push("deb_lat", 8'hFF); pop(bus.in0);
    @(posedge clk);
    #1;
    push("deb_up", 8'hFE); pop(bus.in0);
    @(negedge clk) bus.p1[0] = 1'b0;
    settle();
    #1;
    push("deb_down", 8'hFF); pop(bus.in0);
    @(negedge clk) bus.coin = 1'b1;
    clks(2);
    ticks(4);
    @(posedge clk);
    #1;
    push("coin_pend", 8'h01); pop(busy());
    @(posedge clk);
    #1;
    push("coin_t2", 8'hFF); pop(bus.in0);
    @(posedge clk);
    #1;
    push("coin_t3", 8'hDF); pop(bus.in0);
    @(negedge clk) bus.coin = 1'b0;
    settle();
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("coin_f%0d", k), k < 4 ? 8'hDF : 8'hFF);
      push($sformatf("busy_f%0d", k), k < 8 ? 8'h01 : 8'h00);
      frame();
      #1;
      pop(bus.in0);
      pop(busy());
    end
    coin_press();
    #1;
    push("sat_start", 8'hDF); pop(bus.in0);
    repeat (4) coin_press();
    for (int k = 1; k <= 34; k++) begin
      push($sformatf("sat_f%0d", k), (k < 32 && (k % 8) < 4) ? 8'hDF : 8'hFF);
      frame();
      #1;
      pop(bus.in0);
    end
    push("sat_busy", 8'h00); pop(busy());
    @(negedge clk) bus.p2[2] = 1'b1;
    settle();
    #1;
    push("shr_in0", 8'hFB); pop(bus.in0);
    push("shr_in1", 8'hFB); pop(bus.in1);
    @(negedge clk) bus.cocktail = 1'b1;
    clks(2);
    #1;
    push("ckt_in0", 8'hFF); pop(bus.in0);
    push("ckt_in1", 8'hFB); pop(bus.in1);
    @(negedge clk) begin
      bus.p2[2] = 1'b0;
      bus.p2[5] = 1'b1;
    end
    settle();
    #1;
    push("ckt_st_in0", 8'hFF); pop(bus.in0);
    push("ckt_st_in1", 8'hBF); pop(bus.in1);
    @(negedge clk) bus.cocktail = 1'b0;
    clks(2);
    #1;
    push("shr_st_in0", 8'hFF); pop(bus.in0);
    push("shr_st_in1", 8'hBF); pop(bus.in1);
    @(negedge clk) bus.p2[5] = 1'b0;
    settle();
    coin_press();
    #1;
    push("mid_start", 8'hDF); pop(bus.in0);
    frame();
    frame();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    push("mid_rst_in0", 8'hFF); pop(bus.in0);
    push("mid_rst_busy", 8'h00); pop(busy());
    clks(3);
    @(negedge clk) reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      push($sformatf("post_rst_f%0d", k), 8'hFF);
      frame();
      #1;
      pop(bus.in0);
    end
    push("post_rst_busy", 8'h00); pop(busy());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
